// File: rtl/rv32_mod_bus_arbiter_if.sv
// Shared memory bus between the instruction/data arbiter (master side)
// and the downstream bus target (slave side).
interface rv32_mod_bus_arbiter_if;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_data_o;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_data_i;

   modport master (
      output bus_req, bus_wr, bus_be, bus_addr, bus_data_o,
      input  bus_ack, bus_err, bus_data_i
   );

   modport slave (
      input  bus_req, bus_wr, bus_be, bus_addr, bus_data_o,
      output bus_ack, bus_err, bus_data_i
   );
endinterface

// File: rtl/rv32_mod_bus_arbiter.sv
// Two-port (instruction / data) arbiter onto a single memory bus, with
// data-priority bounded by MAX_DATA_RUN and an optional bus timeout.
module rv32_mod_bus_arbiter #(
   parameter int unsigned MAX_DATA_RUN   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        instr_req,
   input  logic [31:0]                 instr_addr,
   output logic                        instr_ack,
   output logic                        instr_err,
   output logic [31:0]                 instr_data_o,
   input  logic                        data_req,
   input  logic                        data_wr,
   input  logic [3:0]                  data_be,
   input  logic [31:0]                 data_addr,
   input  logic [31:0]                 data_data_i,
   output logic                        data_ack,
   output logic                        data_err,
   output logic [31:0]                 data_data_o,
   rv32_mod_bus_arbiter_if.master      bus
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t      state, state_nxt;
   logic [3:0]  run_cnt;
   logic [7:0]  tmo_cnt;
   logic        grant_i, grant_d, bus_done, tmo_hit;

   assign grant_i  = (state == GNT_I);
   assign grant_d  = (state == GNT_D);
   assign bus_done = bus.bus_ack | bus.bus_err;
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !bus_done &&
                     (tmo_cnt == 8'(TIMEOUT_CYCLES));

   // Both ack and err high is reported as an error only.
   assign instr_ack    = grant_i & bus.bus_ack & ~bus.bus_err;
   assign instr_err    = grant_i & (bus.bus_err | tmo_hit);
   assign data_ack     = grant_d & bus.bus_ack & ~bus.bus_err;
   assign data_err     = grant_d & (bus.bus_err | tmo_hit);
   assign instr_data_o = bus.bus_data_i;
   assign data_data_o  = bus.bus_data_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (instr_req && (!data_req || run_cnt == 4'(MAX_DATA_RUN)))
               state_nxt = GNT_I;
            else if (data_req)
               state_nxt = GNT_D;
         end
         GNT_I, GNT_D: begin
            if (bus_done || tmo_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt        <= '0;
         tmo_cnt        <= '0;
         bus.bus_req    <= 1'b0;
         bus.bus_wr     <= 1'b0;
         bus.bus_be     <= '0;
         bus.bus_addr   <= '0;
         bus.bus_data_o <= '0;
      end else begin
         bus.bus_req <= (state_nxt != IDLE);
         if (state == IDLE && state_nxt == GNT_I) begin
            run_cnt        <= '0;
            tmo_cnt        <= '0;
            bus.bus_wr     <= 1'b0;
            bus.bus_be     <= '1;
            bus.bus_addr   <= instr_addr;
            bus.bus_data_o <= '0;
         end else if (state == IDLE && state_nxt == GNT_D) begin
            // Only data grants that make a waiting instruction wait longer count.
            run_cnt        <= instr_req ? run_cnt + 4'd1 : '0;
            tmo_cnt        <= '0;
            bus.bus_wr     <= data_wr;
            bus.bus_be     <= data_be;
            bus.bus_addr   <= data_addr;
            bus.bus_data_o <= data_data_i;
         end else if (state != IDLE && !bus_done && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Directed and randomized checks of rv32_mod_bus_arbiter against a
// transaction-level model of grant order, bus fields and responses.
module tb_rv32_mod_bus_arbiter;
   localparam int MAXRUN = 4;
   localparam int TMO    = 8;

   logic        clk, reset;
   logic        i_req, d_req, d_wr, b_ack, b_err;
   logic [31:0] i_addr, d_addr, d_wdata, b_rdata;
   logic [3:0]  d_be;
   logic        ia, ie, da, de;
   logic [31:0] instr_data_o, data_data_o;
   int          vectors, miscompares, streak;
   bit          win_i;

   rv32_mod_bus_arbiter_if bif ();
   assign bif.bus_ack    = b_ack;
   assign bif.bus_err    = b_err;
   assign bif.bus_data_i = b_rdata;

   rv32_mod_bus_arbiter #(.MAX_DATA_RUN(MAXRUN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .instr_req(i_req), .instr_addr(i_addr), .instr_ack(ia), .instr_err(ie),
      .instr_data_o(instr_data_o),
      .data_req(d_req), .data_wr(d_wr), .data_be(d_be), .data_addr(d_addr),
      .data_data_i(d_wdata), .data_ack(da), .data_err(de), .data_data_o(data_data_o),
      .bus(bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic new_data;
      d_req   = 1'b1;
      d_wr    = 1'($urandom_range(0, 1));
      d_be    = 4'($urandom);
      d_addr  = $urandom;
      d_wdata = $urandom;
   endtask

   // Called in an IDLE cycle with requests already driven; runs one full
   // transaction for the expected winner and returns in the following IDLE cycle.
   task automatic txn(input bit is_i, input int wait_cyc, input int kind,
                      input bit stray, input logic [31:0] rd);
      logic [31:0] ea;
      logic        ew, ok, er;
      logic [3:0]  eb, eresp;
      ea = is_i ? i_addr : d_addr;
      ew = is_i ? 1'b0 : d_wr;
      eb = is_i ? 4'hF : d_be;
      ok = (kind == 0);
      er = (kind != 0);
      b_ack = stray; b_err = 1'b0; b_rdata = $urandom;
      #1;
      chk("idle_req", bif.bus_req, 0);
      chk("idle_resp", {ia, ie, da, de}, 0);
      chk("idle_mirror_i", instr_data_o, b_rdata);
      tick;
      for (int c = 0; c <= wait_cyc; c++) begin
         if (c == wait_cyc) begin
            b_ack = (kind != 1); b_err = (kind != 0); b_rdata = rd;
         end else begin
            b_ack = 1'b0; b_err = 1'b0; b_rdata = $urandom;
         end
         #1;
         eresp = (c < wait_cyc) ? 4'b0000 : (is_i ? {ok, er, 2'b00} : {2'b00, ok, er});
         chk("gnt_req", bif.bus_req, 1);
         chk("gnt_addr", bif.bus_addr, ea);
         chk("gnt_wr", bif.bus_wr, ew);
         chk("gnt_be", bif.bus_be, eb);
         if (!is_i) chk("gnt_wdata", bif.bus_data_o, d_wdata);
         chk("gnt_resp", {ia, ie, da, de}, eresp);
         chk("gnt_mirror_d", data_data_o, b_rdata);
         if (c < wait_cyc) tick;
      end
      tick;
      b_ack = 1'b0; b_err = 1'b0;
      #1;
      chk("post_req", bif.bus_req, 0);
      chk("post_resp", {ia, ie, da, de}, 0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; streak = 0;
      reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_be = 4'hF;
      i_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'h1234; b_ack = 1'b1; b_err = 1'b0;
      b_rdata = 32'h0;
      #2 reset = 1'b0;
      // Reset values, with requests and a stray ack present
      tick; tick;
      #1;
      chk("rst_req", bif.bus_req, 0);
      chk("rst_wr", bif.bus_wr, 0);
      chk("rst_be", bif.bus_be, 0);
      chk("rst_addr", bif.bus_addr, 0);
      chk("rst_wdata", bif.bus_data_o, 0);
      chk("rst_resp", {ia, ie, da, de}, 0);
      reset = 1'b1;
      #1;
      chk("rel_req", bif.bus_req, 0);
      i_req = 1'b0; d_req = 1'b0; b_ack = 1'b0;
      tick;

      // Lone instruction read, ack on the third grant cycle
      i_req = 1'b1; i_addr = 32'h100;
      txn(1'b1, 2, 0, 1'b0, 32'h0000_0013);
      i_req = 1'b0;

      // Data write with exact fields held until ack
      d_req = 1'b1; d_wr = 1'b1; d_be = 4'b0011; d_addr = 32'h1000_0004; d_wdata = 32'hDEAD_BEEF;
      txn(1'b0, 2, 0, 1'b0, $urandom);

      // Contention with both requests held: D,D,D,D,I,D,D,D,D,I
      i_req = 1'b1; i_addr = 32'h200; d_wr = 1'b0; d_be = 4'hF; d_addr = 32'h300;
      for (int k = 0; k < 10; k++) txn((k % 5) == 4, 0, 0, 1'b0, $urandom);
      i_req = 1'b0;

      // Simultaneous ack and err reported as error only
      txn(1'b0, 1, 2, 1'b0, $urandom);
      d_req = 1'b0; i_req = 1'b1;
      txn(1'b1, 0, 2, 1'b1, $urandom);
      i_req = 1'b0;

      // Timeout on a silent bus, then a stray ack in IDLE
      d_req = 1'b1; d_addr = 32'h500;
      tick;
      for (int k = 1; k <= TMO; k++) begin
         #1;
         chk("tmo_wait_req", bif.bus_req, 1);
         chk("tmo_wait_resp", {ia, ie, da, de}, 0);
         tick;
      end
      #1;
      chk("tmo_err", {ia, ie, da, de}, 4'b0001);
      d_req = 1'b0;
      tick;
      chk("tmo_post_req", bif.bus_req, 0);
      chk("tmo_post_resp", {ia, ie, da, de}, 0);
      b_ack = 1'b1;
      #1;
      chk("stray_resp", {ia, ie, da, de}, 0);
      tick;
      b_ack = 1'b0;
      chk("stray_req", bif.bus_req, 0);

      // Reset in GNT_D cycle 2 after two contended data grants
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h600; d_addr = 32'h700;
      txn(1'b0, 0, 0, 1'b0, $urandom);
      txn(1'b0, 0, 0, 1'b0, $urandom);
      tick;
      #1;
      chk("rmid_gnt1", bif.bus_req, 1);
      tick;
      b_ack = 1'b1;
      reset = 1'b0;
      #1;
      chk("rmid_req", bif.bus_req, 0);
      chk("rmid_addr", bif.bus_addr, 0);
      chk("rmid_resp", {ia, ie, da, de}, 0);
      reset = 1'b1; b_ack = 1'b0;
      // Run count must restart from zero
      for (int k = 0; k < 5; k++) txn(k == 4, 0, 0, 1'b0, $urandom);

      // Randomized traffic against the grant-order model
      streak = 0;
      i_req = 1'b0; d_req = 1'b0;
      for (int n = 0; n < 150; n++) begin
         if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req = 1'b1; i_addr = $urandom;
         end
         if (!d_req && $urandom_range(0, 1) == 1) new_data();
         if (!i_req && !d_req) new_data();
         win_i = i_req && !(d_req && streak < MAXRUN);
         txn(win_i, $urandom_range(0, 3), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), $urandom);
         streak = (!win_i && i_req) ? streak + 1 : 0;
         if (win_i) i_req = 1'b0;
         else       d_req = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
